// File: rtl/dly_cmd_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dly_cmd_sequencer
// Purpose  : Time-multiplexed controller for the gearbox delay-line address
//            bus. Per-channel load/adjust/read requests are latched as pending
//            commands and granted round-robin. Each grant becomes one
//            address/strobe sequence to the gearbox. The tap value returned
//            after settling is captured into a per-channel register bank.
// Ports    : clk, rst (sync, active-low)
//            usr_dly_ld / usr_dly_adj / usr_dly_incdec / usr_rd_dly_value :
//                per-channel request pulses and adjust direction
//            g2f_dly_tap_value     : tap value of the addressed gearbox site
//            f2g_dly_addr / f2g_dly_ld / f2g_dly_adj / f2g_dly_incdec :
//                gearbox delay-control bus
//            usr_dly_tap_value_out : captured tap, channel k at [k*TW +: TW]
//            usr_dly_done          : one-cycle completion pulse per channel
//            busy                  : sequencer is not idle
// Revision : 1.0 - initial release
// ============================================================================
module dly_cmd_sequencer #(
    parameter int                      NUM_GB_SITES = 20,
    parameter logic [NUM_GB_SITES-1:0] DLY_LOC      = 'h0_C117,
    parameter int                      NUM_CH       = 20,
    parameter int                      ADDR_WIDTH   = 5,
    parameter int                      TAP_WIDTH    = 6,
    parameter int                      SETTLE_CYC   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             usr_dly_ld,
    input  logic [NUM_CH-1:0]             usr_dly_adj,
    input  logic [NUM_CH-1:0]             usr_dly_incdec,
    input  logic [NUM_CH-1:0]             usr_rd_dly_value,
    input  logic [TAP_WIDTH-1:0]          g2f_dly_tap_value,
    output logic [ADDR_WIDTH-1:0]         f2g_dly_addr,
    output logic                          f2g_dly_ld,
    output logic                          f2g_dly_adj,
    output logic                          f2g_dly_incdec,
    output logic [NUM_CH*TAP_WIDTH-1:0]   usr_dly_tap_value_out,
    output logic [NUM_CH-1:0]             usr_dly_done,
    output logic                          busy
);

    // ------------------------------------------------------------------
    // Elaboration-time channel map
    // ------------------------------------------------------------------
    function automatic int f_num_mapped();
        int n;
        n = 0;
        for (int s = 0; s < NUM_GB_SITES; s++) begin
            if (DLY_LOC[s]) n++;
        end
        return (n < NUM_CH) ? n : NUM_CH;
    endfunction

    // Channel k -> index of the k-th set bit of DLY_LOC
    function automatic logic [NUM_CH*ADDR_WIDTH-1:0] f_site_tbl();
        logic [NUM_CH*ADDR_WIDTH-1:0] t;
        int                           k;
        t = '0;
        k = 0;
        for (int s = 0; s < NUM_GB_SITES; s++) begin
            if (DLY_LOC[s] && (k < NUM_CH)) begin
                t[k*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(s);
                k++;
            end
        end
        return t;
    endfunction

    function automatic logic [NUM_CH-1:0] f_map_mask();
        logic [NUM_CH-1:0] m;
        m = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (k < f_num_mapped()) m[k] = 1'b1;
        end
        return m;
    endfunction

    localparam int                           c_NUM_MAPPED = f_num_mapped();
    localparam logic [NUM_CH*ADDR_WIDTH-1:0] c_SITE_TBL   = f_site_tbl();
    localparam logic [NUM_CH-1:0]            c_MAP_MASK   = f_map_mask();
    localparam int                           c_CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int                           c_CNT_W      = $clog2(SETTLE_CYC + 1);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_SETUP   = 3'd1;
    localparam logic [2:0] c_ST_STROBE  = 3'd2;
    localparam logic [2:0] c_ST_SETTLE  = 3'd3;
    localparam logic [2:0] c_ST_CAPTURE = 3'd4;

    localparam logic [1:0] c_OP_LD  = 2'd0;
    localparam logic [1:0] c_OP_ADJ = 2'd1;
    localparam logic [1:0] c_OP_RD  = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]                  r_state;
    logic [2:0]                  w_state_nxt;
    logic [c_CH_W-1:0]           r_ch;
    logic [1:0]                  r_op;
    logic [c_CH_W-1:0]           r_rr_ptr;
    logic [c_CNT_W-1:0]          r_cnt;
    logic [NUM_CH-1:0]           r_ld_p;
    logic [NUM_CH-1:0]           r_adj_p;
    logic [NUM_CH-1:0]           r_rd_p;
    logic [NUM_CH-1:0]           r_inc_p;
    logic [ADDR_WIDTH-1:0]       r_addr;
    logic                        r_incdec;
    logic [NUM_CH*TAP_WIDTH-1:0] r_tap;
    logic [NUM_CH-1:0]           r_done;

    // ------------------------------------------------------------------
    // Round-robin arbiter: first requester at or after r_rr_ptr, wrapping
    // within the mapped channels only.
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] w_req;
    logic              w_grant_vld;
    logic [c_CH_W-1:0] w_grant_ch;
    logic [c_CH_W-1:0] w_idx;
    logic [1:0]        w_grant_op;
    int                w_pos;

    assign w_req = (r_ld_p | r_adj_p | r_rd_p) & c_MAP_MASK;

    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_ch  = '0;
        w_pos       = 0;
        w_idx       = '0;
        for (int i = 0; i < c_NUM_MAPPED; i++) begin
            w_pos = int'(r_rr_ptr) + i;
            if (w_pos >= c_NUM_MAPPED) w_pos = w_pos - c_NUM_MAPPED;
            w_idx = c_CH_W'(w_pos);
            if (!w_grant_vld && w_req[w_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_ch  = w_idx;
            end
        end
    end

    // ld > adj > rd within the granted channel
    always_comb begin
        w_grant_op = c_OP_RD;
        if (r_ld_p[w_grant_ch])       w_grant_op = c_OP_LD;
        else if (r_adj_p[w_grant_ch]) w_grant_op = c_OP_ADJ;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) r_state <= c_ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:    if (w_grant_vld) w_state_nxt = c_ST_SETUP;
            c_ST_SETUP:   w_state_nxt = (r_op == c_OP_RD) ? c_ST_SETTLE : c_ST_STROBE;
            c_ST_STROBE:  w_state_nxt = c_ST_SETTLE;
            c_ST_SETTLE:  if (r_cnt == c_CNT_W'(SETTLE_CYC - 1)) w_state_nxt = c_ST_CAPTURE;
            c_ST_CAPTURE: w_state_nxt = c_ST_IDLE;
            default:      w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Pending bits. Clears happen in SETUP; a coincident request wins.
    // Every op captures the tap, so any served op also retires a read.
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] w_sel;
    logic [NUM_CH-1:0] w_clr_ld;
    logic [NUM_CH-1:0] w_clr_adj;
    logic [NUM_CH-1:0] w_clr_rd;
    logic [NUM_CH-1:0] w_set_adj;

    assign w_sel     = NUM_CH'(1) << r_ch;
    assign w_clr_rd  = (r_state == c_ST_SETUP) ? w_sel : '0;
    assign w_clr_ld  = ((r_state == c_ST_SETUP) && (r_op == c_OP_LD))  ? w_sel : '0;
    assign w_clr_adj = ((r_state == c_ST_SETUP) && (r_op == c_OP_ADJ)) ? w_sel : '0;
    assign w_set_adj = usr_dly_adj & c_MAP_MASK;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ld_p  <= '0;
            r_adj_p <= '0;
            r_rd_p  <= '0;
            r_inc_p <= '0;
        end else begin
            r_ld_p  <= (r_ld_p  & ~w_clr_ld)  | (usr_dly_ld & c_MAP_MASK);
            r_adj_p <= (r_adj_p & ~w_clr_adj) | w_set_adj;
            r_rd_p  <= (r_rd_p  & ~w_clr_rd)  | (usr_rd_dly_value & c_MAP_MASK);
            r_inc_p <= (r_inc_p & ~w_set_adj) | (usr_dly_incdec & w_set_adj);
        end
    end

    // ------------------------------------------------------------------
    // Command datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ch     <= '0;
            r_op     <= c_OP_LD;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_incdec <= 1'b0;
            r_tap    <= '0;
            r_done   <= '0;
        end else begin
            r_done <= '0;
            r_cnt  <= (r_state == c_ST_SETTLE) ? r_cnt + 1'b1 : '0;
            if ((r_state == c_ST_IDLE) && w_grant_vld) begin
                r_ch     <= w_grant_ch;
                r_op     <= w_grant_op;
                // Address is loaded at grant so it is already valid in SETUP
                r_addr   <= c_SITE_TBL[w_grant_ch*ADDR_WIDTH +: ADDR_WIDTH];
                r_rr_ptr <= (int'(w_grant_ch) == c_NUM_MAPPED - 1) ? '0 : w_grant_ch + 1'b1;
            end
            if (r_state == c_ST_SETUP) begin
                r_incdec <= r_inc_p[r_ch];
            end
            if (r_state == c_ST_CAPTURE) begin
                r_tap[r_ch*TAP_WIDTH +: TAP_WIDTH] <= g2f_dly_tap_value;
                r_done[r_ch]                       <= 1'b1;
            end
        end
    end

    // During SETUP the direction follows inc_p live (so a merged adjust's
    // latest direction is used); from STROBE on it is held in r_incdec.
    assign f2g_dly_addr          = r_addr;
    assign f2g_dly_incdec        = (r_state == c_ST_SETUP) ? r_inc_p[r_ch] : r_incdec;
    assign f2g_dly_ld            = (r_state == c_ST_STROBE) && (r_op == c_OP_LD);
    assign f2g_dly_adj           = (r_state == c_ST_STROBE) && (r_op == c_OP_ADJ);
    assign usr_dly_tap_value_out = r_tap;
    assign usr_dly_done          = r_done;
    assign busy                  = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dly_cmd_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dly_cmd_sequencer
// Purpose  : Directed self-checking bench for dly_cmd_sequencer with default
//            parameters (channels 0..6 -> sites 0,1,2,4,8,14,15; settle 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dly_cmd_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic [19:0]  usr_dly_ld;
    logic [19:0]  usr_dly_adj;
    logic [19:0]  usr_dly_incdec;
    logic [19:0]  usr_rd_dly_value;
    logic [5:0]   g2f_dly_tap_value;
    logic [4:0]   f2g_dly_addr;
    logic         f2g_dly_ld;
    logic         f2g_dly_adj;
    logic         f2g_dly_incdec;
    logic [119:0] usr_dly_tap_value_out;
    logic [19:0]  usr_dly_done;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    dly_cmd_sequencer dut (
        .clk                   (clk),
        .rst                   (rst),
        .usr_dly_ld            (usr_dly_ld),
        .usr_dly_adj           (usr_dly_adj),
        .usr_dly_incdec        (usr_dly_incdec),
        .usr_rd_dly_value      (usr_rd_dly_value),
        .g2f_dly_tap_value     (g2f_dly_tap_value),
        .f2g_dly_addr          (f2g_dly_addr),
        .f2g_dly_ld            (f2g_dly_ld),
        .f2g_dly_adj           (f2g_dly_adj),
        .f2g_dly_incdec        (f2g_dly_incdec),
        .usr_dly_tap_value_out (usr_dly_tap_value_out),
        .usr_dly_done          (usr_dly_done),
        .busy                  (busy)
    );

    always #5 clk = ~clk;

    // Advance to the next cycle; observe/drive 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] slot(input int k);
        return usr_dly_tap_value_out[k*6 +: 6];
    endfunction

    task automatic clr_req();
        usr_dly_ld       = '0;
        usr_dly_adj      = '0;
        usr_dly_incdec   = '0;
        usr_rd_dly_value = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int n_ld;
        int n_adj;
        int n_dn;

        rst = 1'b0;
        clr_req();
        g2f_dly_tap_value = '0;
        do_reset();

        // ---------------- reset state ----------------
        chk("rst_addr",   f2g_dly_addr, 0);
        chk("rst_ld",     f2g_dly_ld, 0);
        chk("rst_adj",    f2g_dly_adj, 0);
        chk("rst_incdec", f2g_dly_incdec, 0);
        chk("rst_busy",   busy, 0);
        chk("rst_done",   usr_dly_done, 0);
        chk("rst_taps",   usr_dly_tap_value_out, 0);

        // ---------------- ld on ch3 -> site 4 ----------------
        g2f_dly_tap_value = 6'h2A;
        usr_dly_ld = 20'h8;
        for (int c = 1; c <= 8; c++) begin
            tick();
            clr_req();
            if (c >= 2) chk("t1_addr", f2g_dly_addr, 4);
            chk("t1_ld",   f2g_dly_ld, (c == 3));
            chk("t1_adj",  f2g_dly_adj, 0);
            chk("t1_busy", busy, (c >= 2 && c <= 6));
            chk("t1_done", usr_dly_done, (c == 7) ? 20'h8 : 20'h0);
            if (c == 7) chk("t1_slot3", slot(3), 6'h2A);
        end

        // ---------------- adj on ch0/5/6 together ----------------
        do_reset();
        g2f_dly_tap_value = 6'h11;
        usr_dly_adj    = 20'h61;
        usr_dly_incdec = 20'h41;
        for (int c = 1; c <= 20; c++) begin
            tick();
            clr_req();
            chk("t2_adj", f2g_dly_adj, (c == 3 || c == 9 || c == 15));
            chk("t2_ld",  f2g_dly_ld, 0);
            if (c == 3)  begin chk("t2_addr0",  f2g_dly_addr, 0);  chk("t2_inc0",  f2g_dly_incdec, 1); end
            if (c == 9)  begin chk("t2_addr5",  f2g_dly_addr, 14); chk("t2_inc5",  f2g_dly_incdec, 0); end
            if (c == 15) begin chk("t2_addr6",  f2g_dly_addr, 15); chk("t2_inc6",  f2g_dly_incdec, 1); end
            chk("t2_done", usr_dly_done,
                (c == 7) ? 20'h1 : (c == 13) ? 20'h20 : (c == 19) ? 20'h40 : 20'h0);
        end
        chk("t2_slot0", slot(0), 6'h11);
        chk("t2_slot5", slot(5), 6'h11);
        chk("t2_slot6", slot(6), 6'h11);

        // ---------------- round-robin after ch5 served ----------------
        do_reset();
        g2f_dly_tap_value = 6'h07;
        usr_rd_dly_value = 20'h20;
        for (int c = 1; c <= 6; c++) begin
            tick();
            clr_req();
            if (c == 2) chk("t3_addr5", f2g_dly_addr, 14);
        end
        chk("t3_done5", usr_dly_done, 20'h20);
        usr_rd_dly_value = 20'h41;
        for (int c = 1; c <= 11; c++) begin
            tick();
            clr_req();
            chk("t3_strobe", {f2g_dly_ld, f2g_dly_adj}, 0);
            if (c == 2) chk("t3_addr_first",  f2g_dly_addr, 15);
            if (c == 7) chk("t3_addr_second", f2g_dly_addr, 0);
            chk("t3_done", usr_dly_done, (c == 6) ? 20'h40 : (c == 11) ? 20'h1 : 20'h0);
        end
        chk("t3_slot6", slot(6), 6'h07);

        // ---------------- ld + rd on ch2 merge ----------------
        g2f_dly_tap_value = 6'h19;
        usr_dly_ld       = 20'h4;
        usr_rd_dly_value = 20'h4;
        n_ld = 0; n_adj = 0; n_dn = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            clr_req();
            if (f2g_dly_ld)      n_ld++;
            if (f2g_dly_adj)     n_adj++;
            if (usr_dly_done[2]) n_dn++;
            if (c == 7) chk("t4_done_time", usr_dly_done, 20'h4);
        end
        chk("t4_ld_count",   n_ld, 1);
        chk("t4_adj_count",  n_adj, 0);
        chk("t4_done_count", n_dn, 1);
        chk("t4_slot2",      slot(2), 6'h19);

        // second adj while pending: one strobe, latest direction
        usr_dly_adj    = 20'h4;
        usr_dly_incdec = 20'h0;
        n_ld = 0; n_adj = 0; n_dn = 0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            clr_req();
            if (c == 1) begin
                usr_dly_adj    = 20'h4;
                usr_dly_incdec = 20'h4;
            end
            if (f2g_dly_ld)      n_ld++;
            if (f2g_dly_adj)     n_adj++;
            if (usr_dly_done[2]) n_dn++;
            if (c == 3) begin
                chk("t4b_adj_at3", f2g_dly_adj, 1);
                chk("t4b_inc_at3", f2g_dly_incdec, 1);
                chk("t4b_addr",    f2g_dly_addr, 2);
            end
        end
        chk("t4b_adj_count",  n_adj, 1);
        chk("t4b_ld_count",   n_ld, 0);
        chk("t4b_done_count", n_dn, 1);

        // ---------------- unmapped channel 10 ----------------
        usr_dly_ld       = 20'h400;
        usr_dly_adj      = 20'h400;
        usr_rd_dly_value = 20'h400;
        for (int c = 1; c <= 10; c++) begin
            tick();
            clr_req();
            chk("t5_busy",   busy, 0);
            chk("t5_strobe", {f2g_dly_ld, f2g_dly_adj}, 0);
            chk("t5_done",   usr_dly_done, 0);
        end
        chk("t5_slot10", slot(10), 0);

        // ---------------- reset during STROBE ----------------
        g2f_dly_tap_value = 6'h3C;
        usr_dly_ld = 20'h2;
        for (int c = 1; c <= 3; c++) begin
            tick();
            clr_req();
        end
        chk("t6_in_strobe", f2g_dly_ld, 1);
        rst = 1'b0;
        usr_rd_dly_value = 20'h10;
        tick();
        rst = 1'b1;
        clr_req();
        chk("t6_addr",   f2g_dly_addr, 0);
        chk("t6_ld",     f2g_dly_ld, 0);
        chk("t6_adj",    f2g_dly_adj, 0);
        chk("t6_incdec", f2g_dly_incdec, 0);
        chk("t6_busy",   busy, 0);
        chk("t6_done",   usr_dly_done, 0);
        chk("t6_taps",   usr_dly_tap_value_out, 0);
        n_dn = 0; n_ld = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (busy) n_ld++;
            if (usr_dly_done != 0) n_dn++;
        end
        chk("t6_idle_after", n_ld, 0);
        chk("t6_no_done",    n_dn, 0);

        usr_dly_ld = 20'h2;
        for (int c = 1; c <= 8; c++) begin
            tick();
            clr_req();
            if (c >= 2) chk("t6b_addr", f2g_dly_addr, 1);
            chk("t6b_ld",   f2g_dly_ld, (c == 3));
            chk("t6b_done", usr_dly_done, (c == 7) ? 20'h2 : 20'h0);
            if (c == 7) chk("t6b_slot1", slot(1), 6'h3C);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dly_cmd_sequencer.md
# dly_cmd_sequencer

Time-multiplexed controller for the gearbox delay-line address bus. It serves up to NUM_CH user delay channels, each mapped to an I_DELAY/O_DELAY site selected by a location mask. User load, adjust and read requests are latched as pending commands, then granted round-robin and issued one at a time as address/strobe sequences to the gearbox. The tap value read back after each command is captured into a per-channel register bank. It sits between the fabric user logic and the gearbox delay-control port, one instance per gearbox bank.

## Interface
- NUM_GB_SITES, 20, number of gearbox delay sites in the bank
- DLY_LOC, 'h0_C117, NUM_GB_SITES-bit mask; channel k maps to the site index of the k-th set bit, counting from LSB
- NUM_CH, 20, user channel count; mapped channels = min(NUM_CH, popcount(DLY_LOC))
- ADDR_WIDTH, 5, site address width, ≥ clog2(NUM_GB_SITES)
- TAP_WIDTH, 6, tap value width
- SETTLE_CYC, 2, wait cycles (≥1) between command and tap sampling
- clk  in  1  block clock
- rst  in  1  reset, synchronous, active-low
- usr_dly_ld  in  NUM_CH  per-channel load request, single-cycle pulse
- usr_dly_adj  in  NUM_CH  per-channel adjust request, single-cycle pulse
- usr_dly_incdec  in  NUM_CH  direction, sampled with usr_dly_adj (1 = increment)
- usr_rd_dly_value  in  NUM_CH  per-channel tap read request, single-cycle pulse
- g2f_dly_tap_value  in  TAP_WIDTH  tap value of the addressed site, from the gearbox
- f2g_dly_addr  out  ADDR_WIDTH  site address to the gearbox
- f2g_dly_ld  out  1  load strobe
- f2g_dly_adj  out  1  adjust strobe
- f2g_dly_incdec  out  1  direction to the gearbox
- usr_dly_tap_value_out  out  NUM_CH*TAP_WIDTH  captured tap per channel; channel k occupies slice [k*TAP_WIDTH +: TAP_WIDTH]
- usr_dly_done  out  NUM_CH  one-cycle pulse when channel k's command completes
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- Channel-to-site map is a constant computed at elaboration. Requests on unmapped channels are ignored. Their tap slices and done bits stay at 0.
- Each channel has pending bits ld_p, adj_p and rd_p, plus an inc_p register.
  - A request pulse sets the matching pending bit.
  - An adj pulse also loads inc_p from usr_dly_incdec.
  - A repeated request of the same type while it is still pending merges into a single execution. For adj, the latest incdec value wins.
- Op priority within a channel is ld > adj > rd.
- Any executed op clears that channel's rd_p, because every op captures the tap value.
- If a pending bit is set and cleared in the same cycle, set wins.
- Arbitration: in IDLE, the lowest-numbered requesting channel at or after rr_ptr is granted, with wrap-around. After a grant, rr_ptr = granted channel + 1, modulo the mapped-channel count.
- FSM states:
  - IDLE: if any request is pending, latch the channel and op, then go to SETUP.
  - SETUP: drive f2g_dly_addr = site(ch) and f2g_dly_incdec = inc_p. Clear the served pending bit. For ld/adj go to STROBE; for rd go to SETTLE.
  - STROBE: assert f2g_dly_ld or f2g_dly_adj for exactly this one cycle, then go to SETTLE.
  - SETTLE: count SETTLE_CYC cycles, then go to CAPTURE.
  - CAPTURE: register g2f_dly_tap_value into slot ch and register usr_dly_done[ch]=1, then go to IDLE.
- f2g_dly_addr and f2g_dly_incdec hold their values from SETUP through IDLE until the next SETUP.
- Strobes are 0 in every state other than STROBE. At most one strobe is high in any cycle.

## Timing
- When rst=0 at a clock edge, the following apply on the next cycle:
  - State is IDLE.
  - All pending bits are 0 and rr_ptr=0.
  - f2g_dly_addr=0, f2g_dly_ld=0, f2g_dly_adj=0, f2g_dly_incdec=0.
  - All tap slices are 0, usr_dly_done=0 and busy=0.
- Reset mid-command aborts the command with no done pulse. Request pulses that coincide with rst=0 are dropped.
- Latency from a request pulse in cycle 0 to the done pulse, with the queue empty and no competing channels:
  - ld/adj: done in cycle 5+SETTLE_CYC.
  - rd: done in cycle 4+SETTLE_CYC.
  - The updated tap slice is visible in the same cycle as the done pulse.
- Throughput: one command per 4+SETTLE_CYC cycles for ld/adj, and one per 3+SETTLE_CYC cycles for rd. Back-to-back grants need no extra IDLE dwell beyond one cycle.
- busy rises in the cycle after IDLE grants and falls in the cycle after CAPTURE.

## Test plan
All scenarios use the default parameters: mapped channels 0..6 → sites 0, 1, 2, 4, 8, 14, 15; SETTLE_CYC=2.
- ld pulse on ch3 in cycle 0, with g2f tap = 6'h2A:
  - f2g_dly_addr=4 from cycle 2.
  - f2g_dly_ld is high only in cycle 3.
  - done[3] is high in cycle 7 and slot 3 = 6'h2A.
- adj pulses on ch0, ch5 and ch6 in the same cycle, with incdec = 1, 0, 1:
  - Three strobes at addresses 0, 14, 15, in that order, with incdec 1, 0, 1.
  - Done pulses are 6 cycles apart.
- Round-robin after ch5 has been served, with ch0 and ch6 both requesting: ch6 is granted first, then ch0.
- ld and rd pulsed on ch2 in the same cycle: exactly one ld strobe and exactly one done[2].
  - A second adj pulse arriving while adj is pending produces one strobe only, using the latest incdec.
- Request on unmapped ch10: busy stays 0, no strobe fires, and slot 10 = 0.
- rst=0 sampled during STROBE: on the next cycle all outputs are 0 and pending bits are cleared, and no done pulse occurs. A fresh ld on ch1 afterwards completes normally.
